// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Hits are serviced in the request cycle. Misses evict a dirty victim, then fill.
// A core halt writes back every dirty line and then parks the cache in DONE.
module data_cache #(
  parameter int LINES  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_is_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       resp_rdata,
  output logic              stall,
  input  logic              halted,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_FLUSH_SCAN, S_FLUSH_WB, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  // Line storage
  logic             r_valid [LINES];
  logic             r_dirty [LINES];
  logic [TAG_W-1:0] r_tag   [LINES];
  logic [31:0]      r_data  [LINES];

  // Miss context latched so the transaction survives req_valid dropping
  logic [IDX_W-1:0] r_miss_idx;
  logic [TAG_W-1:0] r_miss_tag;
  logic [IDX_W-1:0] r_scan_idx, w_scan_idx_next;

  // Registered memory interface
  logic              r_mem_req, w_mem_req_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [31:0]       r_mem_wdata, w_mem_wdata_next;

  logic [IDX_W-1:0] w_req_idx, w_cur_idx;
  logic [TAG_W-1:0] w_req_tag, w_cur_tag;
  logic [1:0]       w_lane;
  logic             w_hit, w_ack, w_service, w_hit_store, w_miss, w_install;
  logic             w_scan_last;
  logic [31:0]      w_store_word;

  assign w_req_idx   = req_addr[IDX_W+1:2];
  assign w_req_tag   = req_addr[ADDR_W-1:IDX_W+2];
  assign w_lane      = req_addr[1:0];
  assign w_hit       = r_valid[w_req_idx] & (r_tag[w_req_idx] == w_req_tag);
  assign w_ack       = r_mem_req & mem_ack;
  assign w_service   = (r_state == S_IDLE) & req_valid & ~halted;
  assign w_hit_store = w_service & w_hit & req_we;
  assign w_miss      = w_service & ~w_hit;
  assign w_install   = (r_state == S_FILL) & w_ack;
  assign w_scan_last = (r_scan_idx == IDX_W'(LINES - 1));
  // In IDLE the miss being opened is the live request; afterwards use the latch
  assign w_cur_idx   = (r_state == S_IDLE) ? w_req_idx : r_miss_idx;
  assign w_cur_tag   = (r_state == S_IDLE) ? w_req_tag : r_miss_tag;

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign flush_done = (r_state == S_DONE);

  // Store merge: whole word or a single little-endian byte lane
  always_comb begin
    w_store_word = r_data[w_req_idx];
    if (req_is_word) begin
      w_store_word = req_wdata;
    end else begin
      w_store_word[{w_lane, 3'b000} +: 8] = req_wdata[7:0];
    end
  end

  // Load data straight from the array; bytes are zero-extended
  always_comb begin
    resp_rdata = '0;
    if (w_hit) begin
      resp_rdata = req_is_word ? r_data[w_req_idx]
                               : {24'b0, r_data[w_req_idx][{w_lane, 3'b000} +: 8]};
    end
  end

  // Stall whenever the request cannot be answered this cycle; forced low in reset
  always_comb begin
    stall = 1'b0;
    if (rst_b) begin
      case (r_state)
        S_IDLE:  stall = req_valid & (halted | ~w_hit);
        S_DONE:  stall = req_valid;
        default: stall = 1'b1;
      endcase
    end
  end

  // Next-state and scan-index logic
  always_comb begin
    w_state_next    = r_state;
    w_scan_idx_next = r_scan_idx;
    case (r_state)
      S_IDLE: begin
        if (halted) begin
          w_state_next    = S_FLUSH_SCAN;
          w_scan_idx_next = '0;
        end else if (req_valid && !w_hit) begin
          w_state_next = (r_valid[w_req_idx] && r_dirty[w_req_idx]) ? S_WB : S_FILL;
        end
      end
      S_WB:   if (w_ack) w_state_next = S_FILL;
      S_FILL: if (w_ack) w_state_next = S_IDLE;
      S_FLUSH_SCAN: begin
        if (r_valid[r_scan_idx] && r_dirty[r_scan_idx]) begin
          w_state_next = S_FLUSH_WB;
        end else if (w_scan_last) begin
          w_state_next = S_DONE;
        end else begin
          w_scan_idx_next = r_scan_idx + 1'b1;
        end
      end
      S_FLUSH_WB: begin
        if (w_ack) begin
          if (w_scan_last) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next    = S_FLUSH_SCAN;
            w_scan_idx_next = r_scan_idx + 1'b1;
          end
        end
      end
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Memory request for the state being entered; always idles one cycle after an ack
  always_comb begin
    w_mem_req_next   = 1'b0;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = '0;
    w_mem_wdata_next = '0;
    if (!w_ack) begin
      case (w_state_next)
        S_WB: begin
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = {r_tag[w_cur_idx], w_cur_idx, 2'b00};
          w_mem_wdata_next = r_data[w_cur_idx];
        end
        S_FILL: begin
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = {w_cur_tag, w_cur_idx, 2'b00};
        end
        S_FLUSH_WB: begin
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = {r_tag[w_scan_idx_next], w_scan_idx_next, 2'b00};
          w_mem_wdata_next = r_data[w_scan_idx_next];
        end
        default: ;
      endcase
    end
  end

  // FSM state, scan index, miss latch and memory interface registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_scan_idx  <= '0;
      r_miss_idx  <= '0;
      r_miss_tag  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_scan_idx  <= w_scan_idx_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      if (w_miss) begin
        r_miss_idx <= w_req_idx;
        r_miss_tag <= w_req_tag;
      end
    end
  end

  // Valid and dirty bits: cleared by reset, updated by hits, fills and writebacks
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < LINES; i++) begin
        r_valid[i] <= 1'b0;
        r_dirty[i] <= 1'b0;
      end
    end else begin
      if (w_hit_store) r_dirty[w_req_idx] <= 1'b1;
      if ((r_state == S_WB) && w_ack) r_dirty[r_miss_idx] <= 1'b0;
      if ((r_state == S_FLUSH_WB) && w_ack) r_dirty[r_scan_idx] <= 1'b0;
      if (w_install) begin
        r_valid[r_miss_idx] <= 1'b1;
        r_dirty[r_miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: written by fills and store hits; contents meaningless until valid
  always_ff @(posedge clk) begin
    if (w_install) begin
      r_tag[r_miss_idx]  <= r_miss_tag;
      r_data[r_miss_idx] <= mem_rdata;
    end else if (w_hit_store) begin
      r_data[w_req_idx] <= w_store_word;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache with a 3-cycle-ack memory model
// and a flat architectural memory used as the reference for all load data.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_is_word = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] resp_rdata;
  logic        stall, flush_done;
  logic        halted = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  always #5 clk = ~clk;

  data_cache #(.LINES(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_we(req_we), .req_is_word(req_is_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_rdata(resp_rdata),
    .stall(stall), .halted(halted), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  logic [31:0] bmem [logic [31:0]];   // backing memory seen by the responder
  logic [31:0] rmem [logic [31:0]];   // architectural memory (what loads must return)
  xact_t       log_q[$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A51E0F;
  endfunction
  function automatic logic [31:0] rd_b(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] rd_r(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  // Memory responder: ack 3 cycles after mem_req is seen, one-cycle pulse
  int rsp_cnt = 0;
  always @(negedge clk) begin : responder
    xact_t x;
    if (mem_ack) begin
      mem_ack = 1'b0;
      rsp_cnt = 0;
    end else if (rst_b && mem_req) begin
      rsp_cnt++;
      if (rsp_cnt == 3) begin
        x.we   = mem_we;
        x.addr = mem_addr;
        x.data = mem_we ? mem_wdata : rd_b(mem_addr);
        if (mem_we) bmem[mem_addr] = mem_wdata;
        else        mem_rdata = x.data;
        log_q.push_back(x);
        mem_ack = 1'b1;
        rsp_cnt = 0;
      end
    end else begin
      rsp_cnt = 0;
    end
  end

  // Reference line bookkeeping: which word each index currently holds
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [31:0] m_tag   [8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    rmem = bmem;   // un-flushed stores are lost on reset
  endtask

  task automatic cmp_log(input string name, input xact_t exp_q[$]);
    check_eq({name, "_nxact"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_eq($sformatf("%s_we%0d", name, i), log_q[i].we, exp_q[i].we);
      check_eq($sformatf("%s_addr%0d", name, i), log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check_eq($sformatf("%s_wdata%0d", name, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 rst_b = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_is_word = 1'b1; req_addr = 32'h40;
    #1;
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_flush_done", flush_done, 1'b0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    halted = 1'b0;
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic do_req(input logic we, input logic is_word, input logic [31:0] addr,
                        input logic [31:0] wdata, input string name,
                        output logic [31:0] rdata, output int cyc);
    logic [31:0] waddr, vaddr, cur, exp_rd, tag;
    int          idx;
    bit          miss;
    xact_t       e;
    xact_t       exp_q[$];
    waddr = {addr[31:2], 2'b00};
    idx   = int'(addr[4:2]);
    tag   = addr >> 5;
    miss  = !(m_valid[idx] && m_tag[idx] == tag);
    if (miss) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vaddr = (m_tag[idx] << 5) | (32'(idx) << 2);
        e.we = 1'b1; e.addr = vaddr; e.data = rd_r(vaddr);
        exp_q.push_back(e);
      end
      e.we = 1'b0; e.addr = waddr; e.data = '0;
      exp_q.push_back(e);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    cur    = rd_r(waddr);
    exp_rd = is_word ? cur : ((cur >> {addr[1:0], 3'b000}) & 32'hFF);

    @(negedge clk);
    log_q.delete();
    req_valid = 1'b1; req_we = we; req_is_word = is_word;
    req_addr = addr; req_wdata = wdata;
    #1;
    check_eq({name, "_stall_first"}, stall, miss);
    cyc = 0;
    while (stall && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq({name, "_stall_end"}, stall, 1'b0);
    rdata = resp_rdata;
    if (!we) check_eq({name, "_rdata"}, resp_rdata, exp_rd);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;

    if (we) begin
      if (is_word) cur = wdata;
      else         cur[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      rmem[waddr]  = cur;
      m_dirty[idx] = 1'b1;
    end
    cmp_log(name, exp_q);
    $display("%s: %s %s addr=0x%08h wdata=0x%08h rdata=0x%08h miss=%0d xacts=%0d cycles=%0d",
             name, we ? "ST" : "LD", is_word ? "W" : "B", addr, wdata, rdata,
             miss, log_q.size(), cyc);
  endtask

  task automatic do_flush(input string name);
    xact_t e;
    xact_t exp_q[$];
    int    cyc, extra, nlog;
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        e.we = 1'b1; e.addr = (m_tag[i] << 5) | (32'(i) << 2); e.data = rd_r(e.addr);
        exp_q.push_back(e);
        m_dirty[i] = 1'b0;
      end
    end
    @(negedge clk);
    log_q.delete();
    halted = 1'b1;
    #1;
    cyc = 0;
    while (!flush_done && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq({name, "_flush_done"}, flush_done, 1'b1);
    cmp_log(name, exp_q);
    nlog  = log_q.size();
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (mem_req) extra++;
    end
    check_eq({name, "_quiet_after_done"}, extra, 0);
    check_eq({name, "_no_new_xacts"}, log_q.size(), nlog);
    req_valid = 1'b1; req_we = 1'b0; req_is_word = 1'b1; req_addr = 32'h08;
    #1;
    check_eq({name, "_done_stall"}, stall, 1'b1);
    check_eq({name, "_done_sticky"}, flush_done, 1'b1);
    req_valid = 1'b0;
    $display("%s: writebacks=%0d cycles=%0d", name, nlog, cyc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd, a;
    int          cyc;
    logic        we, w;

    model_reset();
    apply_reset();

    // Cold word load, then a repeat with no memory traffic
    bmem[32'h40] = 32'hDEADBEEF;
    rmem[32'h40] = 32'hDEADBEEF;
    do_req(1'b0, 1'b1, 32'h40, '0, "t1_cold_load", rd, cyc);
    check_eq("t1_data", rd, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'h40, '0, "t1_repeat", rd, cyc);

    // Byte store hit, then word load sees the merged lane
    do_req(1'b1, 1'b0, 32'h41, 32'h000000AB, "t2_byte_store", rd, cyc);
    do_req(1'b0, 1'b1, 32'h40, '0, "t2_load", rd, cyc);
    check_eq("t2_data", rd, 32'hDEADABEF);

    // Conflict miss evicts the dirty line first
    bmem[32'h60] = 32'h12345678;
    rmem[32'h60] = 32'h12345678;
    do_req(1'b0, 1'b1, 32'h60, '0, "t3_evict_load", rd, cyc);
    check_eq("t3_data", rd, 32'h12345678);
    check_eq("t3_stall_len_in_range", (cyc >= 6 && cyc <= 12), 1'b1);

    // Store miss to a clean victim, then evict it to expose the merged word
    do_req(1'b1, 1'b0, 32'h22, 32'h00000077, "t6_store_miss", rd, cyc);
    do_req(1'b0, 1'b1, 32'h20, '0, "t6_load_merged", rd, cyc);
    do_req(1'b0, 1'b1, 32'h40, '0, "t6_evict_merged", rd, cyc);

    // Random mix over 8 tags x 8 indices
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255));
      if (w) a[1:0] = 2'b00;
      do_req(we, w, a, $urandom, $sformatf("rnd%0d", n), rd, cyc);
    end
    do_flush("rnd_flush");
    for (int i = 0; i < 256; i += 4) begin
      check_eq($sformatf("mem_after_flush_0x%02h", i), rd_b(32'(i)), rd_r(32'(i)));
    end

    // Flush order with dirty lines at indices 2 and 5 plus a clean line at 3
    apply_reset();
    do_req(1'b1, 1'b1, 32'h08, 32'h11112222, "t4_store_idx2", rd, cyc);
    do_req(1'b1, 1'b1, 32'h14, 32'h33334444, "t4_store_idx5", rd, cyc);
    do_req(1'b0, 1'b1, 32'h0C, '0, "t4_load_idx3", rd, cyc);
    do_flush("t4_flush");
    if (log_q.size() >= 2) begin
      check_eq("t4_first_wb_addr", log_q[0].addr, 32'h08);
      check_eq("t4_second_wb_addr", log_q[1].addr, 32'h14);
    end

    // Reset in the middle of a fill
    apply_reset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_is_word = 1'b1; req_addr = 32'h40;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t5_fill_started", mem_req, 1'b1);
    check_eq("t5_fill_is_read", mem_we, 1'b0);
    #1 rst_b = 1'b0;
    #1;
    check_eq("t5_mem_req_async", mem_req, 1'b0);
    check_eq("t5_stall_async", stall, 1'b0);
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    rst_b = 1'b1;
    model_reset();
    do_req(1'b0, 1'b1, 32'h40, '0, "t5_reload", rd, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
